// File: rtl/dkong3_snd_pkg.sv
// Shared sizes and the offset-binary to two's-complement helper for the
// Donkey Kong 3 sub-CPU sound mixer.
package dkong3_snd_pkg;

   localparam int SAMPLE_W   = 16;
   localparam int FIFO_DEPTH = 2;

   localparam logic [SAMPLE_W-1:0] OB_FLIP = 16'h8000;

   // 0x8000 -> 0, 0xFFFF -> +32767, 0x0000 -> -32768
   function automatic logic signed [SAMPLE_W-1:0] ob_to_s(input logic [SAMPLE_W-1:0] x);
      return signed'(x ^ OB_FLIP);
   endfunction

endpackage

// File: rtl/snd_fifo2.sv
// Two-entry output FIFO with registered head, simultaneous push/pop when full,
// and a sticky overrun flag for results dropped while full.
module snd_fifo2 #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         ready,
   output logic [W-1:0] dout,
   output logic         valid,
   output logic         overrun
);
   import dkong3_snd_pkg::*;

   logic [W-1:0] mem [FIFO_DEPTH];
   logic         rd_ptr, wr_ptr;
   logic [1:0]   cnt;
   logic         empty, full, do_pop, do_push;

   assign empty   = (cnt == 2'd0);
   assign full    = (cnt == 2'(FIFO_DEPTH));
   assign do_pop  = ready & ~empty;
   // a pop frees the slot in the same edge, so a full FIFO still accepts
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0]  <= '0;
         mem[1]  <= '0;
         rd_ptr  <= 1'b0;
         wr_ptr  <= 1'b0;
         cnt     <= 2'd0;
         overrun <= 1'b0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop)
            rd_ptr <= ~rd_ptr;
         cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
         if (push && !do_push)
            overrun <= 1'b1;
      end
   end

   assign valid = ~empty;
   assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/dkong3_snd_mix.sv
// Mixes the two sub-CPU APU streams, averages 2^DECIM_LOG2 strobed samples
// and queues each mean into a small handshake FIFO.
module dkong3_snd_mix
   import dkong3_snd_pkg::*;
#(
   parameter int DECIM_LOG2 = 5
) (
   input  logic                I_SUBCLKx2,
   input  logic                I_RESET,
   input  logic                I_CPU_CE,
   input  logic [SAMPLE_W-1:0] I_SAMPLE0,
   input  logic [SAMPLE_W-1:0] I_SAMPLE1,
   input  logic [1:0]          I_MUTE,
   output logic [SAMPLE_W-1:0] O_SAMPLE,
   output logic                O_VALID,
   input  logic                I_READY,
   output logic                O_OVERRUN
);

   localparam int AW = SAMPLE_W + 1 + DECIM_LOG2;

   logic signed [SAMPLE_W-1:0] s0, s1;
   logic signed [SAMPLE_W:0]   ch0, ch1, sum;
   logic signed [AW-1:0]       acc, acc_next, shifted;
   logic [DECIM_LOG2-1:0]      cnt;
   logic                       wrap;
   logic [SAMPLE_W-1:0]        result;

   always_comb begin
      s0  = ob_to_s(I_SAMPLE0);
      s1  = ob_to_s(I_SAMPLE1);
      ch0 = I_MUTE[0] ? '0 : {s0[SAMPLE_W-1], s0};
      ch1 = I_MUTE[1] ? '0 : {s1[SAMPLE_W-1], s1};
      sum = ch0 + ch1;
   end

   // dividing by 2^(DECIM_LOG2+1) gives the mean of both channels, so the
   // result always fits in SAMPLE_W bits
   assign acc_next = acc + {{DECIM_LOG2{sum[SAMPLE_W]}}, sum};
   assign shifted  = acc_next >>> (DECIM_LOG2 + 1);
   assign result   = shifted[SAMPLE_W-1:0];
   assign wrap     = I_CPU_CE && (cnt == '1);

   always_ff @(posedge I_SUBCLKx2 or posedge I_RESET) begin
      if (I_RESET) begin
         acc <= '0;
         cnt <= '0;
      end else if (I_CPU_CE) begin
         cnt <= cnt + DECIM_LOG2'(1);
         acc <= wrap ? '0 : acc_next;
      end
   end

   snd_fifo2 #(.W(SAMPLE_W)) u_fifo (
      .clk     (I_SUBCLKx2),
      .rst     (I_RESET),
      .push    (wrap),
      .din     (result),
      .ready   (I_READY),
      .dout    (O_SAMPLE),
      .valid   (O_VALID),
      .overrun (O_OVERRUN)
   );

endmodule

// File: tb/tb_dkong3_snd_mix.sv
// Scoreboard bench for dkong3_snd_mix at DECIM_LOG2=2: the driver models each
// 4-sample block as a plain arithmetic mean, the monitor checks handshakes.
module tb_dkong3_snd_mix;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ce = 1'b0;
   logic        ready = 1'b1;
   logic [15:0] s0 = 16'h0, s1 = 16'h0;
   logic [1:0]  mute = 2'b00;
   logic [15:0] o_sample;
   logic        o_valid, o_overrun;

   int n_chk = 0, n_pass = 0;
   int exp_q[$];
   bit ovf_exp = 1'b0;
   int blk_sum = 0, blk_n = 0;

   always #5 clk = ~clk;

   dkong3_snd_mix #(.DECIM_LOG2(2)) dut (
      .I_SUBCLKx2 (clk),
      .I_RESET    (rst),
      .I_CPU_CE   (ce),
      .I_SAMPLE0  (s0),
      .I_SAMPLE1  (s1),
      .I_MUTE     (mute),
      .O_SAMPLE   (o_sample),
      .O_VALID    (o_valid),
      .I_READY    (ready),
      .O_OVERRUN  (o_overrun)
   );

   task automatic check(string nm, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic int chan(logic [15:0] v, bit m);
      return m ? 0 : int'(v) - 32768;
   endfunction

   // one clock; model a CE sample at the edge, where the DUT also sees it
   task automatic cyc(bit c, logic [15:0] a, logic [15:0] b);
      int q;
      ce = c; s0 = a; s1 = b;
      @(posedge clk);
      if (c && !rst) begin
         blk_sum += chan(a, mute[0]) + chan(b, mute[1]);
         blk_n++;
         if (blk_n == 4) begin
            q = blk_sum / 8;
            if (blk_sum < 0 && (blk_sum % 8) != 0) q -= 1;
            if (exp_q.size() < 2) exp_q.push_back(q & 16'hFFFF);
            else ovf_exp = 1'b1;
            blk_sum = 0;
            blk_n   = 0;
         end
      end
      #1;
   endtask

   task automatic drain(string nm);
      int k = 0;
      ready = 1'b1;
      while ((exp_q.size() > 0 || o_valid) && k < 100) begin
         cyc(1'b0, 16'h8000, 16'h8000);
         k++;
      end
      check(nm, exp_q.size(), 0);
   endtask

   // monitor: compare head on every handshake, and hold stability when stalled
   always @(negedge clk) begin
      if (!rst && o_valid) begin
         if (exp_q.size() == 0) check("spurious_valid", int'(o_valid), 0);
         else if (ready) check("word", int'(o_sample), exp_q.pop_front());
         else check("head_hold", int'(o_sample), exp_q[0]);
      end
   end

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", int'(o_valid), 0);
      check("rst_sample", int'(o_sample), 0);
      check("rst_overrun", int'(o_overrun), 0);
      rst = 1'b0;

      // midscale: first word latency
      repeat (3) cyc(1'b1, 16'h8000, 16'h8000);
      check("valid_early", int'(o_valid), 0);
      cyc(1'b1, 16'h8000, 16'h8000);
      check("valid_latency", int'(o_valid), 1);
      drain("drain_zero");

      // full-scale extremes
      repeat (4) cyc(1'b1, 16'hFFFF, 16'hFFFF);
      repeat (4) cyc(1'b1, 16'h0000, 16'h0000);
      drain("drain_extremes");

      // channel 0 muted
      mute = 2'b01;
      repeat (4) cyc(1'b1, 16'h0000, 16'hC000);
      mute = 2'b00;
      drain("drain_mute");

      // overrun: three results while stalled, third dropped
      ready = 1'b0;
      repeat (12) cyc(1'b1, 16'($urandom), 16'($urandom));
      cyc(1'b0, 16'h8000, 16'h8000);
      check("overrun_set", int'(o_overrun), 1);
      check("overrun_model", int'(ovf_exp), 1);
      drain("drain_overrun");
      check("overrun_sticky", int'(o_overrun), 1);

      // sparse strobes at constant input
      n = 0;
      for (int k = 0; k < 2000 && n < 12; k++) begin
         if ($urandom_range(0, 6) == 0) begin
            cyc(1'b1, 16'hA000, 16'hA000);
            n++;
         end else cyc(1'b0, 16'hA000, 16'hA000);
      end
      check("sparse_ce_count", n, 12);
      drain("drain_sparse");

      // random traffic, random mute and backpressure
      for (int k = 0; k < 400; k++) begin
         mute  = 2'($urandom);
         ready = 1'($urandom);
         cyc(1'($urandom), 16'($urandom), 16'($urandom));
      end
      drain("drain_random");

      // reset mid-block with a full FIFO
      while (blk_n != 0) cyc(1'b1, 16'h1234, 16'h5678);
      ready = 1'b0;
      repeat (10) cyc(1'b1, 16'($urandom), 16'($urandom));
      check("pre_rst_full", int'(o_valid), 1);
      rst = 1'b1;
      #1;
      exp_q.delete();
      blk_sum = 0; blk_n = 0; ovf_exp = 1'b0;
      check("rst_mid_valid", int'(o_valid), 0);
      check("rst_mid_overrun", int'(o_overrun), 0);
      check("rst_mid_sample", int'(o_sample), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      ready = 1'b1;
      cyc(1'b1, 16'hFFFF, 16'h8000);
      cyc(1'b1, 16'h0000, 16'h8000);
      cyc(1'b1, 16'hC000, 16'hC000);
      check("post_rst_partial", int'(o_valid), 0);
      cyc(1'b1, 16'hC000, 16'hC000);
      check("post_rst_expect", exp_q.size(), 1);
      drain("drain_post_rst");
      check("post_rst_overrun", int'(o_overrun), int'(ovf_exp));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
